dmem_responder: RTL
===================

Name: dmem_responder

Overview:
- Responder (memory side) of the core's load/store data-memory interface; the core is the initiator.
- Accepts one request at a time over a valid/ready channel and performs word-addressed byte-enabled writes or word reads.
- Returns a response after a configurable fixed latency, over a valid/ready response channel.
- Used as the data memory behind the pipelined RV32I core.

Parameters:
- MEM_WORDS, 1024: number of XLEN-bit words; power of two, at least 4.
- LATENCY, 1: cycles from request acceptance to first rsp_valid_o; legal range 1..8.

Ports:
- clk_i  input  1  clock; all state changes on the rising edge.
- rstn_i  input  1  reset; asynchronous, active-low.
- req_valid_i  input  1  request valid.
- req_ready_o  output  1  responder can accept a request.
- req_we_i  input  1  1 = store, 0 = load.
- req_addr_i  input  XLEN  byte address; bits [1:0] ignored, word index = addr[XLEN-1:2].
- req_be_i  input  XLEN/8  byte enables; lane i covers wdata[8i+7:8i].
- req_wdata_i  input  XLEN  store data, already lane-aligned by the core.
- rsp_valid_o  output  1  response valid.
- rsp_ready_i  input  1  core accepts response.
- rsp_rdata_o  output  XLEN  full read word; 0 for stores and errors.
- rsp_err_o  output  1  request was rejected (out of range or be == 0).

Behaviour:
- FSM states: IDLE, WAIT, RESP. Reset forces IDLE.
- Reset values: rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, latency counter=0.
- req_ready_o = (state == IDLE), combinational. It is 1 during and after reset. Outside IDLE no request is accepted.
- Accept: the rising edge with req_valid_i && req_ready_o. At that edge:
  - the request is registered;
  - stores write the enabled bytes only;
  - loads sample the addressed word into the read-data register.
- Error: word index >= MEM_WORDS, or req_be_i == 0. The memory is not touched, the read data is forced to 0, and the error flag is set.
- After accept:
  - LATENCY == 1: go directly to RESP.
  - Otherwise: go to WAIT with counter = LATENCY-2, decrement each cycle, and go to RESP when the counter reaches 0.
  - rsp_valid_o rises exactly LATENCY cycles after the accept edge.
- RESP: rsp_valid_o=1. rsp_rdata_o and rsp_err_o stay stable until rsp_valid_o && rsp_ready_i. On that edge: go to IDLE, clear rsp_valid_o, and zero rsp_rdata_o and rsp_err_o.
- Throughput: at most one request per LATENCY+1 cycles with rsp_ready_i held high. A new request is not accepted in the response-handshake cycle.
- Store response: rsp_rdata_o=0, rsp_err_o=0 unless rejected.
- Load-after-store to the same word returns the stored bytes, because the write completes at the store's accept edge.
- Inputs on the request channel are ignored outside the accept edge. req_valid_i may be dropped without effect while req_ready_o=0.
- Reset mid-operation: the FSM returns to IDLE immediately and the pending response is discarded. A store already accepted stays written. Memory contents are never cleared by reset.
- Memory powers up undefined; the bench must preload or write before reading.
- Address wrap: none. Addresses beyond the array report an error; they do not alias.

Decomposition:
- riscv_pkg gets:
  - dmem_state_e (IDLE, WAIT, RESP);
  - the constant DmemBeW = XLEN/8;
  - the function dmem_idx_ok(addr, words) for the range check.
- XLEN is reused from riscv_pkg.
- One sub-module, dmem_sram: a MEM_WORDS x XLEN array with a byte-enabled synchronous write and a synchronous read on the same port. No reset.
- dmem_responder holds the FSM, latency counter, response registers and error check.

Test Plan:
- Reset and idle: deassert rstn_i, run 3 cycles idle -> req_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0.
- Store then load:
  - SW addr 0x10, be 4'hF, data 0xDEADBEEF, then load addr 0x10;
  - LATENCY=1 -> rsp_valid_o one cycle after each accept;
  - load returns 0xDEADBEEF, rsp_err_o=0.
- Byte-enable merge: word 0x20 = 0x11223344, then store be 4'b0100 data 0x00AA0000, then load -> 0x11AA3344.
- Error cases:
  - load addr 0x1000 with MEM_WORDS=1024 -> rsp_err_o=1, rdata 0;
  - store be 4'b0000 to addr 0x0 -> rsp_err_o=1, word 0 unchanged on a later load.
- Backpressure and latency, LATENCY=3:
  - rsp_valid_o rises exactly 3 cycles after accept;
  - hold rsp_ready_i=0 for 5 cycles -> rsp_rdata_o stable, req_ready_o=0;
  - handshake -> IDLE next cycle.
- Reset mid-WAIT: store 0xCAFEF00D to 0x40 with LATENCY=4, assert rstn_i 2 cycles after accept -> rsp_valid_o never rises; a later load of 0x40 returns 0xCAFEF00D.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I core definitions: data width, data-memory responder state
// encoding and the data-memory address range check.
package riscv_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned DmemBeW = XLEN / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    // True when the word index addr[XLEN-1:2] falls inside a words-deep array.
    function automatic logic dmem_idx_ok(input logic [XLEN-1:0] addr,
                                         input int unsigned     words);
        logic [XLEN-1:0] idx;
        idx = {2'b00, addr[XLEN-1:2]};
        return idx < XLEN'(words);
    endfunction

endpackage

// File: rtl/dmem_sram.sv
// Single-port MEM_WORDS x XLEN data array.
// Byte-enabled synchronous write and synchronous registered read on the
// same port. Contents are never reset.
//   clk_i    clock
//   we_i     write strobe (bytes selected by be_i)
//   re_i     read strobe (rdata_o updates on the same edge)
//   idx_i    word index
//   be_i     byte-lane enables for writes
//   wdata_i  lane-aligned write data
//   rdata_o  registered read data
module dmem_sram
    import riscv_pkg::*;
#(
    parameter  int unsigned MEM_WORDS = 1024,
    localparam int unsigned IdxW      = $clog2(MEM_WORDS)
) (
    input  logic               clk_i,
    input  logic               we_i,
    input  logic               re_i,
    input  logic [IdxW-1:0]    idx_i,
    input  logic [DmemBeW-1:0] be_i,
    input  logic [XLEN-1:0]    wdata_i,
    output logic [XLEN-1:0]    rdata_o
);

    logic [XLEN-1:0] mem_q [MEM_WORDS];
    logic [XLEN-1:0] rdata_q;

    // Byte-lane write and word read share the port.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int i = 0; i < int'(DmemBeW); i++) begin
                if (be_i[i]) begin
                    mem_q[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
        if (re_i) begin
            rdata_q <= mem_q[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder of the core's load/store data-memory interface.
// One request at a time over valid/ready; the response appears LATENCY
// rising edges after acceptance (counting the accept edge) and is held
// until the core takes it.
//   clk_i        clock
//   rstn_i       asynchronous active-low reset
//   req_valid_i  request valid
//   req_ready_o  idle and able to accept (combinational from state)
//   req_we_i     1 = store, 0 = load
//   req_addr_i   byte address, bits [1:0] ignored
//   req_be_i     byte enables for stores
//   req_wdata_i  lane-aligned store data
//   rsp_valid_o  response valid
//   rsp_ready_i  core accepts response
//   rsp_rdata_o  load data; 0 for stores and rejected requests
//   rsp_err_o    request rejected (index out of range or no byte enable)
module dmem_responder
    import riscv_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 1024,
    parameter int unsigned LATENCY   = 1
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic               req_we_i,
    input  logic [XLEN-1:0]    req_addr_i,
    input  logic [DmemBeW-1:0] req_be_i,
    input  logic [XLEN-1:0]    req_wdata_i,
    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output logic [XLEN-1:0]    rsp_rdata_o,
    output logic               rsp_err_o
);

    localparam int unsigned IdxW = $clog2(MEM_WORDS);
    localparam int unsigned CntW = 3;

    dmem_state_e     state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            rsp_err_q, rsp_err_d;
    logic            load_ok_q, load_ok_d;

    logic            accept_c;
    logic            req_ok_c;
    logic            handshake_c;
    logic            sram_we_c;
    logic            sram_re_c;
    logic [XLEN-1:0] sram_rdata;

    // Request qualification and memory strobes, only on the accept edge.
    assign req_ready_o = (state_q == IDLE);
    assign accept_c    = req_valid_i && req_ready_o;
    assign req_ok_c    = dmem_idx_ok(req_addr_i, MEM_WORDS) && (req_be_i != '0);
    assign handshake_c = rsp_valid_q && rsp_ready_i;
    assign sram_we_c   = accept_c && req_ok_c && req_we_i;
    assign sram_re_c   = accept_c && req_ok_c && !req_we_i;

    dmem_sram #(
        .MEM_WORDS (MEM_WORDS)
    ) u_sram (
        .clk_i   (clk_i),
        .we_i    (sram_we_c),
        .re_i    (sram_re_c),
        .idx_i   (req_addr_i[IdxW+1:2]),
        .be_i    (req_be_i),
        .wdata_i (req_wdata_i),
        .rdata_o (sram_rdata)
    );

    // State and response registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            load_ok_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            load_ok_q   <= load_ok_d;
        end
    end

    // Next-state and response-register logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        load_ok_d   = load_ok_q;

        unique case (state_q)
            IDLE: begin
                if (accept_c) begin
                    rsp_err_d = !req_ok_c;
                    load_ok_d = req_ok_c && !req_we_i;
                    if (LATENCY == 1) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CntW'(LATENCY - 2);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (handshake_c) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    load_ok_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The SRAM output register is the read-data register; load_ok_q (a flop)
    // zeroes it for stores, errors, after the handshake and through reset.
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_rdata_o = load_ok_q ? sram_rdata : '0;

endmodule
